bxtreme_result_collector: RTL and testbench

BXTREME_RESULT_COLLECTOR -- requirements
Module: bxtreme_result_collector

---
 rtl/bxtreme_result_collector.sv | 194 +++++++++++++++++++
 tb/tb_bxtreme_result_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bxtreme_result_collector.sv
// Collects per-round victory flags from NPROCS nonce processors and turns
// them into a stream of winning nonces through a 2-entry output FIFO.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            synchronous active-low reset
//   res_valid_i    one round of processor results is valid this cycle
//   res_newblock_i this round is round 0 of a new block (qualified by res_valid_i)
//   victory_i      bit k: processor k met the difficulty (qualified by res_valid_i)
//   found_valid_o  a winning nonce is presented (FIFO not empty)
//   found_ready_i  consumer accepts found_nonce_o
//   found_nonce_o  winning nonce, zero-extended {round, processor index}
//   dropped_o      sticky: a victory was lost since the last new block
//   exhausted_o    every round of the current block has been processed
//   busy_o         searching the current block
module bxtreme_result_collector #(
    parameter int unsigned NPROCS        = 4,
    parameter int unsigned PARTITIONBITS = 2,
    parameter int unsigned ROUNDBITS     = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid_i,
    input  logic              res_newblock_i,
    input  logic [NPROCS-1:0] victory_i,
    output logic              found_valid_o,
    input  logic              found_ready_i,
    output logic [31:0]       found_nonce_o,
    output logic              dropped_o,
    output logic              exhausted_o,
    output logic              busy_o
);

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned COUNT_W = 2;
    localparam logic [ROUNDBITS-1:0] LAST_ROUND = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEARCH    = 2'd1,
        EXHAUSTED = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ROUNDBITS-1:0]   round_q;
    logic [ROUNDBITS-1:0]   round_d;
    logic [NONCE_W-1:0]     entry0_q;
    logic [NONCE_W-1:0]     entry0_d;
    logic [NONCE_W-1:0]     entry1_q;
    logic [NONCE_W-1:0]     entry1_d;
    logic [NONCE_W-1:0]     last_q;
    logic [NONCE_W-1:0]     last_d;
    logic [COUNT_W-1:0]     count_q;
    logic [COUNT_W-1:0]     count_d;
    logic                   dropped_d;
    logic [NONCE_W-1:0]     nonce_d;

    logic                   flush;
    logic                   process;
    logic                   hit;
    logic                   pop;
    logic [ROUNDBITS-1:0]   proc_round;
    logic [PARTITIONBITS-1:0] win_idx;
    logic                   multi;
    logic [NONCE_W-1:0]     new_nonce;

    // Priority encoder: lowest set victory bit wins.
    always_comb begin
        win_idx = '0;
        for (int i = int'(NPROCS) - 1; i >= 0; i--) begin
            if (victory_i[i]) begin
                win_idx = PARTITIONBITS'(i);
            end
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi = |(victory_i & (victory_i - NPROCS'(1)));

    // Round qualification: a newblock round is always processed as round 0.
    assign flush      = res_valid_i & res_newblock_i;
    assign process    = flush | (res_valid_i & (state_q == SEARCH));
    assign proc_round = flush ? '0 : round_q;
    assign hit        = process & (|victory_i);
    // A flush voids any handshake in the same cycle.
    assign pop        = found_valid_o & found_ready_i & ~flush;
    assign new_nonce  = NONCE_W'({proc_round, win_idx});

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, round counter, FIFO and drop-flag update.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        entry0_d  = entry0_q;
        entry1_d  = entry1_q;
        last_d    = last_q;
        count_d   = count_q;
        dropped_d = dropped_o;

        if (process) begin
            round_d = proc_round + ROUNDBITS'(1);
            state_d = (proc_round == LAST_ROUND) ? EXHAUSTED : SEARCH;
        end

        if (flush) begin
            dropped_d = 1'b0;
        end
        if (process && multi) begin
            dropped_d = 1'b1;
        end

        if (pop) begin
            last_d = entry0_q;
        end

        if (flush) begin
            // Old contents are discarded; only the new round-0 entry survives.
            count_d = hit ? COUNT_W'(1) : COUNT_W'(0);
            if (hit) begin
                entry0_d = new_nonce;
            end
        end else begin
            case (count_q)
                COUNT_W'(0): begin
                    if (hit) begin
                        entry0_d = new_nonce;
                        count_d  = COUNT_W'(1);
                    end
                end
                COUNT_W'(1): begin
                    if (pop && hit) begin
                        entry0_d = new_nonce;
                    end else if (pop) begin
                        count_d = COUNT_W'(0);
                    end else if (hit) begin
                        entry1_d = new_nonce;
                        count_d  = COUNT_W'(2);
                    end
                end
                default: begin
                    if (pop && hit) begin
                        entry0_d = entry1_q;
                        entry1_d = new_nonce;
                    end else if (pop) begin
                        entry0_d = entry1_q;
                        count_d  = COUNT_W'(1);
                    end else if (hit) begin
                        dropped_d = 1'b1;
                    end
                end
            endcase
        end

        // Empty FIFO keeps showing the most recently consumed nonce.
        nonce_d = (count_d == COUNT_W'(0)) ? last_d : entry0_d;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            round_q       <= '0;
            entry0_q      <= '0;
            entry1_q      <= '0;
            last_q        <= '0;
            count_q       <= '0;
            found_valid_o <= 1'b0;
            found_nonce_o <= '0;
            dropped_o     <= 1'b0;
            exhausted_o   <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            round_q       <= round_d;
            entry0_q      <= entry0_d;
            entry1_q      <= entry1_d;
            last_q        <= last_d;
            count_q       <= count_d;
            found_valid_o <= (count_d != COUNT_W'(0));
            found_nonce_o <= nonce_d;
            dropped_o     <= dropped_d;
            exhausted_o   <= (state_d == EXHAUSTED);
            busy_o        <= (state_d == SEARCH);
        end
    end

endmodule

// File: tb/tb_bxtreme_result_collector.sv
// Scoreboard bench for bxtreme_result_collector (NPROCS=4, ROUNDBITS=3).
// A queue-based reference model predicts FIFO contents and flags; predicted
// pops go into a scoreboard queue that a negedge monitor drains on handshakes.
module tb_bxtreme_result_collector;

    logic        clk;
    logic        rst;
    logic        res_valid_i;
    logic        res_newblock_i;
    logic [3:0]  victory_i;
    logic        found_valid_o;
    logic        found_ready_i;
    logic [31:0] found_nonce_o;
    logic        dropped_o;
    logic        exhausted_o;
    logic        busy_o;

    bxtreme_result_collector #(
        .NPROCS       (4),
        .PARTITIONBITS(2),
        .ROUNDBITS    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .res_valid_i   (res_valid_i),
        .res_newblock_i(res_newblock_i),
        .victory_i     (victory_i),
        .found_valid_o (found_valid_o),
        .found_ready_i (found_ready_i),
        .found_nonce_o (found_nonce_o),
        .dropped_o     (dropped_o),
        .exhausted_o   (exhausted_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    logic [31:0] last_pop_seen = '0;
    bit check_en = 1'b0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] sb_q[$];
    bit          m_search;
    bit          m_exh;
    int          mround;
    bit          mdropped;
    logic [31:0] mlast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit v, input bit nb,
                                input logic [3:0] vic, input bit rdy);
        bit flush;
        int k;
        if (!r) begin
            mq.delete();
            m_search = 0;
            m_exh    = 0;
            mround   = 0;
            mdropped = 0;
            mlast    = '0;
            return;
        end
        flush = v && nb;
        if (mq.size() > 0 && rdy && !flush) begin
            mlast = mq.pop_front();
            sb_q.push_back(mlast);
        end
        if (flush) begin
            mq.delete();
            mdropped = 0;
            mround   = 0;
        end
        if (flush || (v && m_search)) begin
            if (vic != 4'b0000) begin
                k = -1;
                for (int i = 3; i >= 0; i--) if (vic[i]) k = i;
                if ($countones(vic) > 1) mdropped = 1;
                if (mq.size() < 2) mq.push_back(32'(mround * 4 + k));
                else mdropped = 1;
            end
            if (mround == 7) begin
                mround   = 0;
                m_search = 0;
                m_exh    = 1;
            end else begin
                mround   = mround + 1;
                m_search = 1;
                m_exh    = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid",     32'(found_valid_o), 32'(mq.size() > 0));
        chk("busy",      32'(busy_o),        32'(m_search));
        chk("exhausted", 32'(exhausted_o),   32'(m_exh));
        chk("dropped",   32'(dropped_o),     32'(mdropped));
        chk("nonce",     found_nonce_o,      (mq.size() > 0) ? mq[0] : mlast);
    endtask

    // One cycle: check the previous edge's result, then apply new inputs.
    task automatic step(input bit r, input bit v, input bit nb,
                        input logic [3:0] vic, input bit rdy);
        @(posedge clk);
        #1;
        if (check_en) check_outputs();
        rst            = r;
        res_valid_i    = v;
        res_newblock_i = nb;
        victory_i      = vic;
        found_ready_i  = rdy;
        model_update(r, v, nb, vic, rdy);
        if (!r) check_en = 1'b1;
    endtask

    // Monitor: a consumed handshake must match the next predicted pop.
    always @(negedge clk) begin
        if (check_en && rst && found_valid_o && found_ready_i
            && !(res_valid_i && res_newblock_i)) begin
            pop_cnt++;
            last_pop_seen = found_nonce_o;
            if (sb_q.size() == 0) begin
                chk("unexpected_pop", found_nonce_o, 32'hFFFF_FFFF);
            end else begin
                chk("pop_nonce", found_nonce_o, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit r, v, nb, rdy;
        logic [3:0] vic;

        rst = 1'b0; res_valid_i = 1'b0; res_newblock_i = 1'b0;
        victory_i = '0; found_ready_i = 1'b0;

        step(0, 0, 0, 4'b0000, 1);
        step(0, 0, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        chk("reset_valid", 32'(found_valid_o), 32'd0);
        chk("reset_nonce", found_nonce_o, 32'd0);

        // Single winner in round 2, continuous ready
        base = pop_cnt;
        step(1, 1, 1, 4'b0000, 1);
        step(1, 1, 0, 4'b0000, 1);
        step(1, 1, 0, 4'b0100, 1);
        step(1, 1, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        chk("single_pops", 32'(pop_cnt - base), 32'd1);
        chk("single_nonce", last_pop_seen, 32'h0000_000A);
        chk("single_dropped", 32'(dropped_o), 32'd0);

        // Two winners in round 4: lowest index kept, drop flagged
        step(1, 1, 0, 4'b1010, 1);
        step(1, 0, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        chk("multi_nonce", last_pop_seen, 32'h0000_0011);
        chk("multi_dropped", 32'(dropped_o), 32'd1);

        // Backpressure: three winners, FIFO holds two
        step(1, 1, 1, 4'b0000, 0);
        step(1, 1, 0, 4'b0001, 0);
        step(1, 1, 0, 4'b0001, 0);
        step(1, 1, 0, 4'b0001, 0);
        step(1, 0, 0, 4'b0000, 0);
        chk("full_dropped", 32'(dropped_o), 32'd1);
        base = pop_cnt;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'b0000, 1);
        chk("full_pops", 32'(pop_cnt - base), 32'd2);
        chk("full_last", last_pop_seen, 32'h0000_0008);

        // Exhaustion after 8 rounds, later rounds ignored
        step(1, 1, 1, 4'b0000, 1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        chk("exh_flag", 32'(exhausted_o), 32'd1);
        chk("exh_busy", 32'(busy_o), 32'd0);
        base = pop_cnt;
        step(1, 1, 0, 4'b0001, 1);
        step(1, 0, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        chk("exh_nopush", 32'(pop_cnt - base), 32'd0);
        chk("exh_valid", 32'(found_valid_o), 32'd0);

        // Newblock flush over a full FIFO with a void handshake
        step(1, 1, 1, 4'b0000, 0);
        step(1, 1, 0, 4'b0001, 0);
        step(1, 1, 0, 4'b0010, 0);
        step(1, 1, 1, 4'b0001, 1);
        step(1, 0, 0, 4'b0000, 0);
        chk("flush_nonce", found_nonce_o, 32'h0000_0000);
        chk("flush_valid", 32'(found_valid_o), 32'd1);
        chk("flush_dropped", 32'(dropped_o), 32'd0);
        base = pop_cnt;
        step(1, 0, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        chk("flush_pops", 32'(pop_cnt - base), 32'd1);

        // Reset mid-search with a full FIFO and active inputs
        step(1, 1, 1, 4'b0000, 0);
        step(1, 1, 0, 4'b0001, 0);
        step(1, 1, 0, 4'b0001, 0);
        step(0, 1, 0, 4'b0001, 1);
        step(1, 1, 0, 4'b0001, 1);
        chk("rst_valid", 32'(found_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_nonce", found_nonce_o, 32'd0);
        step(1, 0, 0, 4'b0000, 1);
        chk("rst_ignore", 32'(found_valid_o), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            v   = ($urandom_range(0, 9) < 7);
            nb  = v && ($urandom_range(0, 15) == 0);
            vic = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0000;
            rdy = ($urandom_range(0, 3) != 0);
            step(r, v, nb, vic, rdy);
        end

        for (int i = 0; i < 5; i++) step(1, 0, 0, 4'b0000, 1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
